spi_regfile: RTL and testbench
==============================

Name: spi_regfile

Overview:
- Parametrised SPI-slave register file: successor to the fixed 5x8-bit write-only SPI peripheral.
- Fully synchronous to clk. sclk, cs and sdi are oversampled and edge-detected; sclk is never used as a clock.
- Supports write and read-back frames, configurable address/data widths and register count, frame-length checking and write strobes.
- Sits between the chip-level SPI pins and the configuration registers feeding the datapath (e.g. PWM control).

Parameters:
- ADDR_W, 7, address field width in bits.
- DATA_W, 8, data field width and register width in bits.
- NUM_REGS, 5, number of implemented registers; valid addresses 0..NUM_REGS-1.
- RESET_VAL, 0, reset value loaded into every register (DATA_W bits).

Ports:
- clk  input  1  system clock; the only clock in the block.
- rst  input  1  synchronous, active-high reset.
- sclk  input  1  SPI clock, asynchronous to clk, mode 0.
- cs  input  1  SPI chip select, active-low, asynchronous.
- sdi  input  1  SPI serial data in, MSB first.
- sdo  output  1  SPI serial data out, MSB first.
- regs  output  NUM_REGS*DATA_W  flattened register contents; register k occupies bits [k*DATA_W +: DATA_W].
- wr_stb  output  1  one-clk pulse when a register is written.
- wr_addr  output  ADDR_W  address of the last committed write.
- frame_err  output  1  one-clk pulse when a frame is discarded.

Behaviour:
- Frame format: FRAME_W = 1+ADDR_W+DATA_W bits, MSB first. Bit 0 = R/W (1 = write, 0 = read), then ADDR_W address bits, then DATA_W data bits.
- Synchronisers: sclk, cs and sdi each pass through two clk flops. A third flop on sclk and cs feeds the edge detectors.
- Clock-ratio requirement: sclk frequency must be at most clk/8.
- States: IDLE, SHIFT, COMMIT.
- IDLE -> SHIFT on the synced cs falling edge. Clears bit counter and shift register.
- SHIFT, on each synced sclk rising edge: shift the synced sdi into the shift register; counter += 1.
  - Counter saturates at FRAME_W+1 and never wraps.
- SHIFT -> COMMIT on the synced cs rising edge.
- COMMIT lasts exactly one clk, then -> IDLE.
  - Write frame: valid when counter == FRAME_W and addr < NUM_REGS. Then the register updates, wr_stb = 1 and wr_addr = addr, all in that cycle (the registers are visible on regs the next clk).
  - Read frame: valid when counter == FRAME_W. No register changes.
  - Any other case (wrong length, addr >= NUM_REGS): no register changes; frame_err = 1 for one clk.
- Read data path: on the synced sclk rising edge that completes the address (counter becomes 1+ADDR_W), if R/W = 0, load the out-shifter with the addressed register. An out-of-range address loads all zeros.
  - On each subsequent synced sclk falling edge, present the next bit on sdo, MSB first.
  - MSB is valid on sdo before the first data-phase rising edge.
- sdo is 0 whenever cs is high, during write frames, and during the command/address phase.
- Reset (rst = 1 at a clk edge): all registers = RESET_VAL; state = IDLE; counter = 0; shifters = 0; sdo = 0; wr_stb = 0; wr_addr = 0; frame_err = 0.
  - A reset mid-frame aborts the frame. Any remaining sclk edges are ignored until the next cs falling edge after reset deasserts.
- cs is re-sampled high by the synchroniser before any frame starts. A cs low already present at reset release does not start a frame until cs goes high then low.
- Simultaneous sclk rising edge and cs rising edge in the same synced cycle: the cs edge wins; that sclk edge is not counted.
- Back-to-back frames: a cs falling edge seen during COMMIT is honoured on the following clk (IDLE).

Optional Feature:
- Macro: SPI_READBACK_EN.
- Defined: read frames behave as above.
- Undefined:
  - The out-shifter is not implemented and sdo is tied to 0.
  - Read frames (R/W = 0) are treated as invalid: no register change and frame_err pulses.

Test Plan:
- Defaults; send 16-bit 0x81A5 -> reg1 = 0xA5, wr_stb pulses once, wr_addr = 1, all other regs 0x00.
- Send 0x85FF (addr 5, NUM_REGS = 5) -> no register changes, frame_err pulses once, wr_stb stays 0.
- Send only the first 15 bits of 0x8233, then raise cs -> reg2 unchanged, frame_err pulses; 17-bit frame likewise rejected.
- After writing reg1 = 0xA5 (SPI_READBACK_EN defined), send 0x0100 -> sdo shifts 1,0,1,0,0,1,0,1 in the data phase, registers unchanged. Without the macro: sdo = 0 throughout and frame_err pulses.
- Write reg3 = 0x5A, then assert rst mid-way through a second write frame -> all regs = RESET_VAL, no wr_stb. The next full frame 0x8311 is accepted normally.
- ADDR_W = 4, DATA_W = 16, NUM_REGS = 12; send the 21-bit frame 1,0xB,0xBEEF -> regs[11*16 +: 16] = 0xBEEF, wr_addr = 11.

Source files
------------

// File: rtl/spi_regfile.sv
// spi_regfile: oversampled SPI-slave register file (mode 0, MSB first) with write strobes and frame checking.
// Optional macro SPI_READBACK_EN adds read-back frames on sdo; without it read frames are rejected.
module spi_regfile #(
    parameter int                ADDR_W    = 7,
    parameter int                DATA_W    = 8,
    parameter int                NUM_REGS  = 5,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       cs,
    input  logic                       sdi,
    output logic                       sdo,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic                       wr_stb,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);
    // state  | meaning
    // IDLE   | waiting for a synced cs falling edge
    // SHIFT  | frame in progress, counting synced sclk rising edges
    // COMMIT | one clk: validate the frame, write a register or flag an error
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_W);
`ifdef SPI_READBACK_EN
    localparam logic RD_EN = 1'b1;
`else
    localparam logic RD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t             state_q, state_d;
    logic [2:0]         sclk_sync_q, sclk_sync_d;
    logic [2:0]         cs_sync_q, cs_sync_d;
    logic [1:0]         sdi_sync_q, sdi_sync_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0]  regs_q [NUM_REGS];
    logic [DATA_W-1:0]  regs_d [NUM_REGS];
    logic               wr_stb_q, wr_stb_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic               frame_err_q, frame_err_d;
    logic               cs_pend_q, cs_pend_d;

    logic               sclk_rise, cs_rise, cs_fall;
    logic               f_rw, f_addr_ok, f_len_ok;
    logic [ADDR_W-1:0]  f_addr;
    logic [DATA_W-1:0]  f_data;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
    assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];

    assign f_rw     = shreg_q[FRAME_W-1];
    assign f_addr   = shreg_q[DATA_W +: ADDR_W];
    assign f_data   = shreg_q[DATA_W-1:0];
    assign f_len_ok = (cnt_q == CNT_FULL);

    always_comb begin
        f_addr_ok = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (f_addr == ADDR_W'(k)) f_addr_ok = 1'b1;
        end
    end

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], sclk};
        cs_sync_d   = {cs_sync_q[1:0], cs};
        sdi_sync_d  = {sdi_sync_q[0], sdi};
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        regs_d      = regs_q;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        frame_err_d = 1'b0;
        cs_pend_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall || cs_pend_q) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            end
            SHIFT: begin
                // a cs rise in the same synced cycle as an sclk rise ends the frame without counting it
                if (cs_rise) begin
                    state_d = COMMIT;
                end else if (sclk_rise) begin
                    shreg_d = {shreg_q[FRAME_W-2:0], sdi_sync_q[1]};
                    if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
                end
            end
            COMMIT: begin
                state_d   = IDLE;
                cs_pend_d = cs_fall;
                if (f_len_ok && f_rw && f_addr_ok) begin
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (f_addr == ADDR_W'(k)) regs_d[k] = f_data;
                    end
                    wr_stb_d  = 1'b1;
                    wr_addr_d = f_addr;
                end else if (!(f_len_ok && !f_rw && RD_EN)) begin
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Synchronisers reset low so a cs already low at reset release cannot look like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            sdi_sync_q  <= '0;
            cnt_q       <= '0;
            shreg_q     <= '0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
            cs_pend_q   <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= RESET_VAL;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            sdi_sync_q  <= sdi_sync_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
            cs_pend_q   <= cs_pend_d;
            regs_q      <= regs_d;
        end
    end

`ifdef SPI_READBACK_EN
    logic              sclk_fall;
    logic [DATA_W-1:0] osh_q, osh_d;
    logic              rd_act_q, rd_act_d;
    logic              sdo_q, sdo_d;
    logic [DATA_W-1:0] rd_word;

    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];

    // Load on the address-completing rise; the following fall puts the MSB out ahead of the first data rise.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (shreg_d[ADDR_W-1:0] == ADDR_W'(k)) rd_word = regs_q[k];
        end
        osh_d    = osh_q;
        rd_act_d = rd_act_q;
        sdo_d    = sdo_q;
        if (state_q != SHIFT || cs_rise) begin
            osh_d    = '0;
            rd_act_d = 1'b0;
            sdo_d    = 1'b0;
        end else if (sclk_rise && cnt_q == CNT_ADDR && !shreg_d[ADDR_W]) begin
            osh_d    = rd_word;
            rd_act_d = 1'b1;
        end else if (sclk_fall && rd_act_q) begin
            sdo_d = osh_q[DATA_W-1];
            osh_d = osh_q << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            osh_q    <= '0;
            rd_act_q <= 1'b0;
            sdo_q    <= 1'b0;
        end else begin
            osh_q    <= osh_d;
            rd_act_q <= rd_act_d;
            sdo_q    <= sdo_d;
        end
    end

    assign sdo = sdo_q;
`else
    assign sdo = 1'b0;
`endif

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
        assign regs[k*DATA_W +: DATA_W] = regs_q[k];
    end

    assign wr_stb    = wr_stb_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_regfile.sv
// Directed bench for spi_regfile: default 5x8 instance plus a 12x16 instance with 4-bit addresses.
module tb_spi_regfile;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst, sclk, cs, sdi;
    logic sdo_a, wr_stb_a, frame_err_a;
    logic [39:0] regs_a;
    logic [6:0]  wr_addr_a;
    logic sdo_w, wr_stb_w, frame_err_w;
    logic [191:0] regs_w;
    logic [3:0]   wr_addr_w;

    int checks = 0;
    int errors = 0;
    int n_wr_a = 0, n_err_a = 0, n_wr_w = 0;
    int wr0, err0, wrw0;
    logic       sdo_cmd_or, sdo_all_or;
    logic [7:0] rd_word;

    always #5 clk = ~clk;

    spi_regfile dut_a (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .sdi(sdi), .sdo(sdo_a),
        .regs(regs_a), .wr_stb(wr_stb_a), .wr_addr(wr_addr_a), .frame_err(frame_err_a)
    );

    spi_regfile #(.ADDR_W(4), .DATA_W(16), .NUM_REGS(12)) dut_w (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .sdi(sdi), .sdo(sdo_w),
        .regs(regs_w), .wr_stb(wr_stb_w), .wr_addr(wr_addr_w), .frame_err(frame_err_w)
    );

    always @(posedge clk) begin
        if (wr_stb_a)    n_wr_a  <= n_wr_a + 1;
        if (frame_err_a) n_err_a <= n_err_a + 1;
        if (wr_stb_w)    n_wr_w  <= n_wr_w + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        wr0  = n_wr_a;
        err0 = n_err_a;
        wrw0 = n_wr_w;
    endtask

    // Sends val[nbits-1:0] MSB first; asserts rst before bit abort_at (-1 = never).
    task automatic send_frame(input logic [31:0] val, input int nbits, input int abort_at);
        sdo_cmd_or = 1'b0;
        sdo_all_or = 1'b0;
        rd_word    = '0;
        cs = 1'b0;
        wait_clk(HALF);
        for (int k = 0; k < nbits; k++) begin
            if (k == abort_at) begin
                rst = 1'b1;
                wait_clk(3);
                rst = 1'b0;
                wait_clk(2);
            end
            sdi = val[nbits-1-k];
            wait_clk(HALF);
            sdo_all_or = sdo_all_or | sdo_a;
            if (k < 8) sdo_cmd_or = sdo_cmd_or | sdo_a;
            else       rd_word = {rd_word[6:0], sdo_a};
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
        wait_clk(HALF);
        cs  = 1'b1;
        sdi = 1'b0;
        wait_clk(12);
    endtask

    initial begin
        rst = 1'b1; cs = 1'b1; sclk = 1'b0; sdi = 1'b0;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(5);
        check("reset_regs", 256'(regs_a), 256'(40'h0));
        check("reset_wr_addr", 256'(wr_addr_a), 256'(7'h0));
        check("reset_sdo", 256'(sdo_a), 256'(1'b0));
        check("reset_flags", 256'({wr_stb_a, frame_err_a}), 256'(2'b00));
        check("reset_regs_w", 256'(regs_w), 256'(192'h0));

        snap();
        send_frame(32'h81A5, 16, -1);
        check("wr1_regs", 256'(regs_a), 256'(40'h00_0000_A500));
        check("wr1_stb_count", 256'(n_wr_a - wr0), 256'(1));
        check("wr1_wr_addr", 256'(wr_addr_a), 256'(7'd1));
        check("wr1_no_err", 256'(n_err_a - err0), 256'(0));
        check("wr1_sdo_quiet", 256'(sdo_all_or), 256'(1'b0));

        snap();
        send_frame(32'h85FF, 16, -1);
        check("oor_regs", 256'(regs_a), 256'(40'h00_0000_A500));
        check("oor_err_count", 256'(n_err_a - err0), 256'(1));
        check("oor_no_stb", 256'(n_wr_a - wr0), 256'(0));

        snap();
        send_frame(32'h4119, 15, -1);
        check("short_regs", 256'(regs_a), 256'(40'h00_0000_A500));
        check("short_err_count", 256'(n_err_a - err0), 256'(1));
        check("short_no_stb", 256'(n_wr_a - wr0), 256'(0));

        snap();
        send_frame(32'h10467, 17, -1);
        check("long_regs", 256'(regs_a), 256'(40'h00_0000_A500));
        check("long_err_count", 256'(n_err_a - err0), 256'(1));
        check("long_no_stb", 256'(n_wr_a - wr0), 256'(0));

        snap();
        send_frame(32'h0100, 16, -1);
        check("rd_regs", 256'(regs_a), 256'(40'h00_0000_A500));
        check("rd_no_stb", 256'(n_wr_a - wr0), 256'(0));
        check("rd_cmd_sdo_low", 256'(sdo_cmd_or), 256'(1'b0));
`ifdef SPI_READBACK_EN
        check("rd_sdo_word", 256'(rd_word), 256'(8'hA5));
        check("rd_no_err", 256'(n_err_a - err0), 256'(0));
`else
        check("rd_sdo_zero", 256'(sdo_all_or), 256'(1'b0));
        check("rd_err_count", 256'(n_err_a - err0), 256'(1));
`endif

        snap();
        send_frame(32'h835A, 16, -1);
        check("wr3_regs", 256'(regs_a), 256'(40'h00_5A00_A500));
        check("wr3_wr_addr", 256'(wr_addr_a), 256'(7'd3));

        snap();
        send_frame(32'h8377, 16, 8);
        check("abort_regs", 256'(regs_a), 256'(40'h0));
        check("abort_no_stb", 256'(n_wr_a - wr0), 256'(0));
        check("abort_wr_addr", 256'(wr_addr_a), 256'(7'h0));

        snap();
        send_frame(32'h8311, 16, -1);
        check("post_rst_regs", 256'(regs_a), 256'(40'h00_1100_0000));
        check("post_rst_stb", 256'(n_wr_a - wr0), 256'(1));
        check("post_rst_wr_addr", 256'(wr_addr_a), 256'(7'd3));
        check("wide_ignores_16b", 256'(n_wr_w - wrw0), 256'(0));

        snap();
        send_frame(32'h1BBEEF, 21, -1);
        check("wide_reg11", 256'(regs_w[11*16 +: 16]), 256'(16'hBEEF));
        check("wide_low_regs", 256'(regs_w[175:0]), 256'(176'h0));
        check("wide_wr_addr", 256'(wr_addr_w), 256'(4'd11));
        check("wide_stb_count", 256'(n_wr_w - wrw0), 256'(1));
        check("narrow_rejects_21b", 256'(regs_a), 256'(40'h00_1100_0000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
